// File: rtl/cpu_mem_pkg.sv
// Shared types for the multi-cycle CPU memory responder: FSM states, data width, error codes.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package cpu_mem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_t;

    // Only "any error" is visible on the port; the code is kept for debug visibility.
    function automatic err_t decode_err(input logic rd, input logic wr,
                                        input logic [1:0] addr_lo, input logic in_range);
        if (rd && wr)
            return ERR_CONFLICT;
        if (addr_lo != 2'b00)
            return ERR_MISALIGN;
        if (!in_range)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word RAM: synchronous write with enable, asynchronous read, no reset.
// Latency: read combinational from addr; write lands at the clock edge.
// Backpressure: none, always ready.
module mem_array_1rw #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_wait_responder.sv
// Unified-port memory responder: one word read/write per request with MemReady/MemError pulse.
// Latency: MemReady exactly LATENCY cycles after the accept cycle.
// Backpressure: requester holds MemRead/MemWrite until MemReady; dropping both while waiting aborts.
module mem_wait_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemError,
    output logic              Busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_wait_responder: LATENCY must be within 1..15");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_wait_responder: DEPTH must be a power of 2");
    end

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    err_t              err_q;

    logic              req;
    logic              accept;
    logic              in_range;
    err_t              err_in;
    err_t              cur_err;
    logic              cur_wr;
    logic              enter_resp;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign req      = MemRead || MemWrite;
    assign accept   = (state == S_IDLE) && req;
    assign in_range = {1'b0, Address} < ADDR_LIMIT;
    assign err_in   = decode_err(MemRead, MemWrite, Address[1:0], in_range);

    // With LATENCY==1 the response is formed on the accept edge, before the latches hold the request.
    assign cur_err    = (state == S_IDLE) ? err_in : err_q;
    assign cur_wr     = (state == S_IDLE) ? MemWrite : wr_q;
    assign ram_idx    = (state == S_IDLE) ? Address[IDX_W+1:2] : idx_q;
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state == S_WAIT) && req && (cnt == 4'd1));
    assign ram_we     = (state == S_RESP) && wr_q && (err_q == ERR_NONE) && !reset;

    mem_array_1rw #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= Address[IDX_W+1:2];
            wdata_q <= WriteData;
            wr_q    <= MemWrite;
            err_q   <= err_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ReadData <= '0;
            MemReady <= 1'b0;
            MemError <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            MemReady <= enter_resp;
            MemError <= enter_resp && (cur_err != ERR_NONE);
            if (enter_resp) begin
                if (cur_err != ERR_NONE)
                    ReadData <= '0;
                else if (!cur_wr)
                    ReadData <= ram_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= 4'(LATENCY - 1);
                        Busy  <= 1'b1;
                        state <= (LATENCY > 1) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (!req) begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end else if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a LATENCY=2 and a LATENCY=1 instance share clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_wait_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        mr0, mw0, mr1, mw1;
    logic [31:0] ad0, ad1, wd0, wd1, rd0, rd1;
    logic        rdy0, rdy1, err0, err1, busy0, busy1;

    mem_wait_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset), .MemRead(mr0), .MemWrite(mw0), .Address(ad0),
        .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0), .MemError(err0), .Busy(busy0)
    );

    mem_wait_responder #(.ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .MemRead(mr1), .MemWrite(mw1), .Address(ad1),
        .WriteData(wd1), .ReadData(rd1), .MemReady(rdy1), .MemError(err1), .Busy(busy1)
    );

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            mr0 = rd; mw0 = wr; ad0 = a; wd0 = w;
        end else begin
            mr1 = rd; mw1 = wr; ad1 = a; wd1 = w;
        end
    endtask

    function automatic logic        rdy_of(input int d);   return (d == 0) ? rdy0  : rdy1;  endfunction
    function automatic logic        err_of(input int d);   return (d == 0) ? err0  : err1;  endfunction
    function automatic logic        busy_of(input int d);  return (d == 0) ? busy0 : busy1; endfunction
    function automatic logic [31:0] rdata_of(input int d); return (d == 0) ? rd0   : rd1;   endfunction
    function automatic int          lat_of(input int d);   return (d == 0) ? 2     : 1;     endfunction

    // One full request: push the expectation, scramble Address/WriteData after accept, wait for MemReady.
    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] w, input logic chk_data, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
        exp_t e;
        int   cyc;
        logic seen;
        sb.push_back('{chk_data, exp_data, exp_err});
        drive(d, rd, wr, a, w);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1)
                drive(d, rd, wr, $urandom, $urandom);
            seen = rdy_of(d);
        end
        check({tag, " latency"}, cyc, lat_of(d));
        e = sb.pop_front();
        check({tag, " err"}, err_of(d), e.err);
        if (e.chk_data)
            check({tag, " data"}, rdata_of(d), e.data);
        check({tag, " busy"}, busy_of(d), 1);
        drive(d, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        check({tag, " pulse end"}, rdy_of(d), 0);
        check({tag, " idle"}, busy_of(d), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic seen;
        int   pulses[$];

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ReadData", rd0, 0);
        check("reset MemReady", rdy0, 0);
        check("reset MemError", err0, 0);
        check("reset Busy", busy0, 0);
        reset = 1'b0;

        // Seed known contents.
        access(0, 0, 1, 32'h0,  32'h0BAD_F00D, 0, 0, 0, "seed w0");
        access(0, 0, 1, 32'h20, 32'h1111_2222, 0, 0, 0, "seed w20");
        access(0, 0, 1, 32'h30, 32'h3030_3030, 0, 0, 0, "seed w30");

        access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, "write 0x10");
        access(0, 1, 0, 32'h10, 0, 1, 32'hDEAD_BEEF, 0, "read 0x10");

        access(0, 1, 0, 32'h13, 0, 1, 32'h0, 1, "misaligned");
        access(0, 1, 0, 32'h10, 0, 1, 32'hDEAD_BEEF, 0, "read after misaligned");

        access(0, 0, 1, 32'h400, 32'h1234, 1, 32'h0, 1, "out of range");
        access(0, 1, 0, 32'h0, 0, 1, 32'h0BAD_F00D, 0, "word0 intact");

        // Abort: drop the strobe in the first WAIT cycle.
        drive(0, 1'b0, 1'b1, 32'h20, 32'hCAFE);
        @(posedge clk); #1;
        check("abort busy in wait", busy0, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy0) seen = 1'b1;
        end
        check("abort no ready", seen, 0);
        check("abort idle", busy0, 0);
        access(0, 1, 0, 32'h20, 0, 1, 32'h1111_2222, 0, "abort readback");

        // Reset in the WAIT cycle that would otherwise lead to RESP.
        drive(0, 1'b0, 1'b1, 32'h30, 32'h55AA);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        check("midreset MemReady", rdy0, 0);
        check("midreset MemError", err0, 0);
        check("midreset Busy", busy0, 0);
        check("midreset ReadData", rd0, 0);
        @(posedge clk); #1;
        check("midreset no late ready", rdy0, 0);
        access(0, 1, 0, 32'h30, 0, 1, 32'h3030_3030, 0, "midreset readback");

        // LATENCY=1 instance.
        access(1, 0, 1, 32'h8, 32'h0000_B00B, 0, 0, 0, "l1 write");
        sb.push_back('{1'b1, 32'h0000_B00B, 1'b0});
        sb.push_back('{1'b1, 32'h0000_B00B, 1'b0});
        drive(1, 1'b1, 1'b0, 32'h8, '0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (rdy1 && sb.size() > 0) begin
                pulses.push_back(c);
                e = sb.pop_front();
                check("b2b data", rd1, e.data);
                check("b2b err", err1, e.err);
            end
        end
        drive(1, 1'b0, 1'b0, '0, '0);
        check("b2b pulse count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            check("b2b first pulse", pulses[0], 1);
            check("b2b second pulse", pulses[1], 3);
        end
        @(posedge clk); #1;
        check("b2b ends idle", busy1, 0);
        check("b2b no extra ready", rdy1, 0);

        access(1, 1, 1, 32'h8, 32'hFFFF_FFFF, 1, 32'h0, 1, "conflict");
        access(1, 1, 0, 32'h8, 0, 1, 32'h0000_B00B, 0, "conflict readback");

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
